// File: rtl/alert_ping_sched_if.sv
// alert_ping_sched_if: ping request/ack and failure report bundle between scheduler and channels
// master: scheduler side (drives req/fail/fail_idx, reads ok); slave: channel side.
interface alert_ping_sched_if #(
  parameter int NAlerts = 4,
  parameter int NEsc = 4,
  parameter int IdxW = $clog2(NAlerts + NEsc)
);
  logic [NAlerts-1:0] alert_ping_req_o;
  logic [NAlerts-1:0] alert_ping_ok_i;
  logic [NEsc-1:0] esc_ping_req_o;
  logic [NEsc-1:0] esc_ping_ok_i;
  logic alert_ping_fail_o;
  logic esc_ping_fail_o;
  logic [IdxW-1:0] fail_idx_o;
  modport master (
    output alert_ping_req_o, esc_ping_req_o, alert_ping_fail_o, esc_ping_fail_o, fail_idx_o,
    input alert_ping_ok_i, esc_ping_ok_i
  );
  modport slave (
    input alert_ping_req_o, esc_ping_req_o, alert_ping_fail_o, esc_ping_fail_o, fail_idx_o,
    output alert_ping_ok_i, esc_ping_ok_i
  );
endinterface

// File: rtl/alert_ping_sched.sv
// alert_ping_sched: round-robin ping scheduler over alert and escalation channels with timeout detection
// clk_i/rst_ni: clock, async active-low reset; en_i: scheduler enable;
// alert_en_i/esc_en_i: per-channel ping enables; period_i/timeout_i: idle and wait windows minus one;
// ping: req/ok per channel, fail pulses and combined failed-channel index.
module alert_ping_sched #(
  parameter int NAlerts = 4,
  parameter int NEsc = 4,
  parameter int TimerW = 16,
  parameter int IdxW = $clog2(NAlerts + NEsc)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [NAlerts-1:0] alert_en_i,
  input  logic [NEsc-1:0]    esc_en_i,
  input  logic [TimerW-1:0]  period_i,
  input  logic [TimerW-1:0]  timeout_i,
  alert_ping_sched_if.master ping
);
  localparam int N = NAlerts + NEsc;
  typedef enum logic [1:0] {IDLE, WAIT, PING} state_e;
  state_e state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d, tgt_q, tgt_d, fail_idx_q, fail_idx_d, nxt_idx, tgt_inc, j;
  logic [TimerW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [N-1:0] req_q, req_d, en_vec, ok_vec;
  logic afail_q, afail_d, efail_q, efail_d, found, tmo, is_alert;
  assign en_vec = {esc_en_i, alert_en_i};
  assign ok_vec = {ping.esc_ping_ok_i, ping.alert_ping_ok_i};
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
  assign tgt_inc = IdxW'((int'(tgt_q) + 1) % N);
  assign is_alert = int'(tgt_q) < NAlerts;
  // a disabled target or an ack in the final window cycle both suppress the failure
  assign tmo = en_vec[tgt_q] && !ok_vec[tgt_q] && cnt_q == timeout_i;
  // first enabled channel at or after ptr, wrapping
  always_comb begin
    nxt_idx = ptr_q;
    found = 1'b0;
    j = '0;
    for (int i = 0; i < N; i++) begin
      j = IdxW'((int'(ptr_q) + i) % N);
      if (!found && en_vec[j]) begin
        nxt_idx = j;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    tgt_d = tgt_q;
    cnt_d = cnt_q;
    req_d = '0;
    afail_d = 1'b0;
    efail_d = 1'b0;
    fail_idx_d = fail_idx_q;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = WAIT;
          cnt_d = '0;
        end
        WAIT: begin
          if (found && cnt_q >= period_i) begin
            state_d = PING;
            tgt_d = nxt_idx;
            cnt_d = '0;
            req_d = N'(1) << nxt_idx;
          end else begin
            cnt_d = found ? cnt_inc : cnt_q;
          end
        end
        PING: begin
          if (!en_vec[tgt_q] || ok_vec[tgt_q] || cnt_q == timeout_i) begin
            state_d = WAIT;
            cnt_d = '0;
            ptr_d = tgt_inc;
            afail_d = tmo && is_alert;
            efail_d = tmo && !is_alert;
            fail_idx_d = tmo ? tgt_q : fail_idx_q;
          end else begin
            cnt_d = cnt_inc;
            req_d = req_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q <= '0;
      tgt_q <= '0;
      cnt_q <= '0;
      req_q <= '0;
      afail_q <= 1'b0;
      efail_q <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      tgt_q <= tgt_d;
      cnt_q <= cnt_d;
      req_q <= req_d;
      afail_q <= afail_d;
      efail_q <= efail_d;
      fail_idx_q <= fail_idx_d;
    end
  end
  assign ping.alert_ping_req_o = req_q[NAlerts-1:0];
  assign ping.esc_ping_req_o = req_q[N-1:NAlerts];
  assign ping.alert_ping_fail_o = afail_q;
  assign ping.esc_ping_fail_o = efail_q;
  assign ping.fail_idx_o = fail_idx_q;
endmodule

// File: tb/tb_alert_ping_sched.sv
// tb_alert_ping_sched: directed self-checking bench for alert_ping_sched
module tb_alert_ping_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [3:0] aen = 4'hf;
  logic [3:0] een = 4'hf;
  logic [15:0] period = 16'd3;
  logic [15:0] timeout = 16'd5;
  logic [7:0] reqv = '0;
  logic [7:0] prev = '0;
  logic [7:0] ack_mask = 8'hff;
  logic [7:0] stray = 8'h00;
  logic [7:0] okv;
  int checks = 0;
  int errors = 0;
  int afail_cnt = 0;
  int efail_cnt = 0;
  int hi = 0;
  int ack_dly = 2;
  alert_ping_sched_if #(.NAlerts(4), .NEsc(4), .IdxW(3)) pif ();
  alert_ping_sched #(.NAlerts(4), .NEsc(4), .TimerW(16), .IdxW(3)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .en_i(en),
    .alert_en_i(aen),
    .esc_en_i(een),
    .period_i(period),
    .timeout_i(timeout),
    .ping(pif)
  );
  always #5 clk = ~clk;
  // one clock: sample outputs just after the edge, then drive this cycle's acks
  task automatic step();
    @(posedge clk);
    #1;
    reqv = {pif.esc_ping_req_o, pif.alert_ping_req_o};
    if (pif.alert_ping_fail_o) afail_cnt++;
    if (pif.esc_ping_fail_o) efail_cnt++;
    hi = (reqv != 0 && reqv == prev) ? hi + 1 : 0;
    prev = reqv;
    okv = (reqv != 0 && hi >= ack_dly) ? (reqv & ack_mask) : 8'h00;
    okv = okv | ((reqv != 0) ? stray : 8'h00);
    pif.alert_ping_ok_i = okv[3:0];
    pif.esc_ping_ok_i = okv[7:4];
  endtask
  // gap: quiet cycles before the ping; len: cycles req held; ends on the first cycle after req drops
  task automatic wait_ping(output int ch, output int len, output int gap);
    logic [7:0] cur;
    gap = 0;
    len = 0;
    ch = -1;
    while (reqv == 0 && gap < 200) begin
      gap++;
      step();
    end
    cur = reqv;
    for (int i = 0; i < 8; i++) if (cur[i]) ch = i;
    while (cur != 0 && reqv == cur && len < 200) begin
      len++;
      step();
    end
  endtask
  task automatic test_reset();
    #12;
    checks++;
    if ({pif.esc_ping_req_o, pif.alert_ping_req_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_req got %h exp 00", {pif.esc_ping_req_o, pif.alert_ping_req_o});
    end
    checks++;
    if ({pif.alert_ping_fail_o, pif.esc_ping_fail_o, pif.fail_idx_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_fail got %b exp 00000", {pif.alert_ping_fail_o, pif.esc_ping_fail_o, pif.fail_idx_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (reqv !== 8'h00) begin
      errors++;
      $display("FAIL idle_disabled_req got %h exp 00", reqv);
    end
  endtask
  task automatic test_round_robin();
    int ch, len, gap;
    en = 1'b1;
    for (int p = 0; p < 9; p++) begin
      wait_ping(ch, len, gap);
      checks++;
      if (ch !== p % 8) begin
        errors++;
        $display("FAIL rr_order ping %0d got ch %0d exp %0d", p, ch, p % 8);
      end
      checks++;
      if (len !== 3) begin
        errors++;
        $display("FAIL rr_len ping %0d got %0d exp 3", p, len);
      end
      if (p > 0) begin
        checks++;
        if (gap !== 4) begin
          errors++;
          $display("FAIL rr_gap ping %0d got %0d exp 4", p, gap);
        end
      end
    end
    checks++;
    if (afail_cnt + efail_cnt !== 0) begin
      errors++;
      $display("FAIL rr_nofail got %0d pulses exp 0", afail_cnt + efail_cnt);
    end
  endtask
  task automatic test_timeout();
    int ch, len, gap, a0;
    a0 = afail_cnt;
    ack_mask = 8'hfb;
    wait_ping(ch, len, gap);
    checks++;
    if (ch !== 1 || len !== 3) begin
      errors++;
      $display("FAIL to_pre got ch %0d len %0d exp ch 1 len 3", ch, len);
    end
    wait_ping(ch, len, gap);
    checks++;
    if (ch !== 2 || len !== 6) begin
      errors++;
      $display("FAIL to_hold got ch %0d len %0d exp ch 2 len 6", ch, len);
    end
    checks++;
    if (pif.alert_ping_fail_o !== 1'b1 || pif.fail_idx_o !== 3'd2) begin
      errors++;
      $display("FAIL to_pulse got fail %b idx %0d exp 1 idx 2", pif.alert_ping_fail_o, pif.fail_idx_o);
    end
    wait_ping(ch, len, gap);
    checks++;
    if (ch !== 3 || len !== 3 || gap !== 4) begin
      errors++;
      $display("FAIL to_next got ch %0d len %0d gap %0d exp 3 3 4", ch, len, gap);
    end
    checks++;
    if (afail_cnt - a0 !== 1) begin
      errors++;
      $display("FAIL to_pulse_cnt got %0d exp 1", afail_cnt - a0);
    end
    ack_mask = 8'hff;
  endtask
  task automatic test_stray_ok();
    int ch, len, gap, a0, e0;
    a0 = afail_cnt;
    e0 = efail_cnt;
    ack_mask = 8'hdf;
    stray = 8'h08;
    wait_ping(ch, len, gap);
    checks++;
    if (ch !== 4 || len !== 3) begin
      errors++;
      $display("FAIL stray_pre got ch %0d len %0d exp ch 4 len 3", ch, len);
    end
    wait_ping(ch, len, gap);
    checks++;
    if (ch !== 5 || len !== 6) begin
      errors++;
      $display("FAIL stray_hold got ch %0d len %0d exp ch 5 len 6", ch, len);
    end
    checks++;
    if (pif.esc_ping_fail_o !== 1'b1 || pif.alert_ping_fail_o !== 1'b0 || pif.fail_idx_o !== 3'd5) begin
      errors++;
      $display("FAIL stray_pulse got esc %b alert %b idx %0d exp 1 0 5", pif.esc_ping_fail_o, pif.alert_ping_fail_o, pif.fail_idx_o);
    end
    stray = 8'h00;
    wait_ping(ch, len, gap);
    checks++;
    if (ch !== 6 || pif.fail_idx_o !== 3'd5) begin
      errors++;
      $display("FAIL stray_after got ch %0d idx %0d exp ch 6 idx 5", ch, pif.fail_idx_o);
    end
    checks++;
    if (efail_cnt - e0 !== 1 || afail_cnt - a0 !== 0) begin
      errors++;
      $display("FAIL stray_cnt got esc %0d alert %0d exp 1 0", efail_cnt - e0, afail_cnt - a0);
    end
    ack_mask = 8'hff;
  endtask
  task automatic test_late_ok();
    int ch, len, gap, f0;
    f0 = afail_cnt + efail_cnt;
    ack_dly = 5;
    wait_ping(ch, len, gap);
    checks++;
    if (ch !== 7 || len !== 6) begin
      errors++;
      $display("FAIL late_hold got ch %0d len %0d exp ch 7 len 6", ch, len);
    end
    checks++;
    if (pif.esc_ping_fail_o !== 1'b0) begin
      errors++;
      $display("FAIL late_nofail got %b exp 0", pif.esc_ping_fail_o);
    end
    wait_ping(ch, len, gap);
    checks++;
    if (ch !== 0 || len !== 6 || gap !== 4) begin
      errors++;
      $display("FAIL late_next got ch %0d len %0d gap %0d exp 0 6 4", ch, len, gap);
    end
    checks++;
    if (afail_cnt + efail_cnt - f0 !== 0) begin
      errors++;
      $display("FAIL late_cnt got %0d exp 0", afail_cnt + efail_cnt - f0);
    end
    ack_dly = 2;
  endtask
  task automatic test_sparse();
    int ch, len, gap, busy;
    int exp_ch [4] = '{2, 0, 2, 0};
    aen = 4'b0101;
    een = 4'b0000;
    for (int p = 0; p < 4; p++) begin
      wait_ping(ch, len, gap);
      checks++;
      if (ch !== exp_ch[p] || len !== 3) begin
        errors++;
        $display("FAIL sparse ping %0d got ch %0d len %0d exp ch %0d len 3", p, ch, len, exp_ch[p]);
      end
    end
    aen = 4'b0000;
    busy = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (reqv != 0) busy++;
    end
    checks++;
    if (busy !== 0) begin
      errors++;
      $display("FAIL none_enabled got %0d req cycles exp 0", busy);
    end
  endtask
  task automatic test_en_drop();
    int ch, len, gap, n, f0;
    f0 = afail_cnt + efail_cnt;
    aen = 4'hf;
    een = 4'hf;
    n = 0;
    while (reqv == 0 && n < 50) begin
      n++;
      step();
    end
    checks++;
    if (reqv !== 8'h02) begin
      errors++;
      $display("FAIL drop_target got %h exp 02", reqv);
    end
    en = 1'b0;
    step();
    checks++;
    if (reqv !== 8'h00 || pif.alert_ping_fail_o !== 1'b0 || pif.esc_ping_fail_o !== 1'b0) begin
      errors++;
      $display("FAIL drop_req got req %h fail %b%b exp 00 00", reqv, pif.alert_ping_fail_o, pif.esc_ping_fail_o);
    end
    for (int i = 0; i < 3; i++) step();
    en = 1'b1;
    wait_ping(ch, len, gap);
    checks++;
    if (ch !== 1 || len !== 3) begin
      errors++;
      $display("FAIL drop_resume got ch %0d len %0d exp ch 1 len 3", ch, len);
    end
    checks++;
    if (afail_cnt + efail_cnt - f0 !== 0) begin
      errors++;
      $display("FAIL drop_cnt got %0d exp 0", afail_cnt + efail_cnt - f0);
    end
  endtask
  task automatic test_async_reset();
    int n;
    n = 0;
    while (reqv == 0 && n < 50) begin
      n++;
      step();
    end
    checks++;
    if (reqv !== 8'h04) begin
      errors++;
      $display("FAIL arst_target got %h exp 04", reqv);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pif.esc_ping_req_o, pif.alert_ping_req_o} !== 8'h00) begin
      errors++;
      $display("FAIL arst_req got %h exp 00", {pif.esc_ping_req_o, pif.alert_ping_req_o});
    end
    checks++;
    if ({pif.alert_ping_fail_o, pif.esc_ping_fail_o, pif.fail_idx_o} !== 5'b0) begin
      errors++;
      $display("FAIL arst_fail got %b exp 00000", {pif.alert_ping_fail_o, pif.esc_ping_fail_o, pif.fail_idx_o});
    end
    en = 1'b0;
    #10;
    rst_n = 1'b1;
  endtask
  initial begin
    pif.alert_ping_ok_i = '0;
    pif.esc_ping_ok_i = '0;
    test_reset();
    test_round_robin();
    test_timeout();
    test_stray_ok();
    test_late_ok();
    test_sparse();
    test_en_drop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alert_ping_sched.md
# alert_ping_sched

Ping scheduler for the alert and escalation channels. It walks round-robin over all enabled alert senders and escalation receivers and issues one ping request at a time. It waits a programmable number of cycles for the channel's ping acknowledge and reports a one-cycle failure pulse with the channel index on timeout. It sits in the alert handler between the CSR-programmed configuration and the per-channel alert receivers and escalation senders, which drive the differential ping/ack wires.

## Interface
- NAlerts, 4: number of alert channels (≥1).
- NEsc, 4: number of escalation channels (≥1).
- TimerW, 16: width of the period/timeout counter.
- IdxW, $clog2(NAlerts+NEsc): channel index width.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- en_i  in  1  scheduler enable (level).
- alert_en_i  in  NAlerts  per-alert-channel ping enable.
- esc_en_i  in  NEsc  per-escalation-channel ping enable.
- period_i  in  TimerW  idle cycles between pings, minus one.
- timeout_i  in  TimerW  ping wait window, minus one.
- alert_ping_req_o  out  NAlerts  one-hot ping request, held for the whole ping.
- alert_ping_ok_i  in  NAlerts  per-channel ping acknowledge.
- esc_ping_req_o  out  NEsc  one-hot ping request.
- esc_ping_ok_i  in  NEsc  per-channel ping acknowledge.
- alert_ping_fail_o  out  1  one-cycle pulse: alert channel timed out.
- esc_ping_fail_o  out  1  one-cycle pulse: escalation channel timed out.
- fail_idx_o  out  IdxW  combined index of the failed channel; valid with either fail pulse, otherwise holds its last value.

## Operation
- Combined channel space: index 0..NAlerts-1 are alert channels; NAlerts..NAlerts+NEsc-1 are escalation channels. The enable vector is {esc_en_i, alert_en_i}.
- State: ptr (IdxW), tgt (IdxW), cnt (TimerW, saturating), FSM with states IDLE, WAIT, PING.
- IDLE:
  - Outputs are quiet.
  - If en_i=1, go to WAIT with cnt=0.
- WAIT:
  - cnt increments each cycle.
  - When cnt ≥ period_i and at least one channel is enabled, tgt = the first enabled index searching from ptr upward with wrap. Go to PING with cnt=0.
  - If no channel is enabled, stay in WAIT and hold cnt.
- PING:
  - The req bit for tgt is asserted every cycle; all other req bits are 0.
  - If ok_i[tgt] is sampled high: drop req, set ptr=(tgt+1) mod (NAlerts+NEsc), and go to WAIT with cnt=0.
  - Else if cnt == timeout_i: drop req, pulse alert_ping_fail_o (tgt<NAlerts) or esc_ping_fail_o (otherwise), set fail_idx_o=tgt, advance ptr as above, and go to WAIT with cnt=0.
  - Else cnt increments.
- Acks on channels other than tgt are ignored in every state.
- Ping ok and timeout in the same cycle: ok wins and no fail is reported.
- Target channel disabled during PING: abort the ping, drop req next cycle, no fail, advance ptr, go to WAIT.
- en_i=0 in any state: go to IDLE next cycle, drop req, no fail, and leave ptr unchanged so that channel is pinged first after re-enable.
- Configuration inputs are sampled live; a change takes effect at the next comparison.

## Timing
- All outputs are registered.
- Reset values: alert_ping_req_o=0, esc_ping_req_o=0, alert_ping_fail_o=0, esc_ping_fail_o=0, fail_idx_o=0. Internally state=IDLE, ptr=0, cnt=0.
- Asynchronous reset mid-ping clears all outputs immediately, with no fail pulse.
- WAIT lasts period_i+1 cycles, because the cnt ≥ period_i compare is made on the cycle cnt reaches period_i.
- Req rises on the first PING cycle, i.e. the clock edge leaving WAIT.
- Req is held for at most timeout_i+1 cycles.
- Ok sampled in PING cycle k (k ≤ timeout_i) gives req low in cycle k+1.
- On timeout, the fail pulse and the req deassertion occur in the same cycle, one cycle after the last req cycle.
- Back-to-back pings on the same channel never overlap; there is at least one WAIT cycle between pings.

## Test plan
- All channels enabled, period_i=3, timeout_i=5, ok returned 2 cycles after req. Required response:
  - pings go in order alert0..3, then esc0..3, then wrap to alert0;
  - each req is high exactly 3 cycles;
  - 4 cycles of quiet between pings;
  - no fail pulse.
- Same setup with alert2 never acking. Required response:
  - alert_ping_req_o=4'b0100 is held 6 cycles;
  - alert_ping_fail_o pulses 1 cycle with fail_idx_o=2;
  - the next ping goes to alert3.
- esc1 never acks while alert3 raises ok during the esc1 ping. Required response: the stray ok is ignored and esc_ping_fail_o pulses with fail_idx_o=5.
- Ok arrives in the final window cycle (cycle index 5 with timeout_i=5). Required response: no fail pulse, and the ping completes normally.
- alert_en_i=4'b0101, esc_en_i=0. Required response:
  - only alert0 and alert2 are pinged, alternately;
  - with all enables 0, the req outputs stay 0 indefinitely.
- Enable and reset disruption mid-ping:
  - en_i dropped during an alert1 ping: req is 0 next cycle, no fail, and alert1 is pinged first after re-enable;
  - rst_ni asserted mid-ping: all outputs are 0 asynchronously.
